// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS main control and the ALU control stage:
// state encodings, opcodes, ALUOp / ALUSrcB / PCSource codes and the control-word layout.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEMADDR   = 4'd2,
        S_MEMREAD   = 4'd3,
        S_MEMWB     = 4'd4,
        S_MEMWRITE  = 4'd5,
        S_EXECUTE   = 4'd6,
        S_RCOMPLETE = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDIEXEC  = 4'd10,
        S_ADDICOMP  = 4'd11
    } state_t;

    localparam logic [5:0] OPC_RTYPE = 6'd0;
    localparam logic [5:0] OPC_LW    = 6'd35;
    localparam logic [5:0] OPC_SW    = 6'd43;
    localparam logic [5:0] OPC_BEQ   = 6'd4;
    localparam logic [5:0] OPC_J     = 6'd2;
    localparam logic [5:0] OPC_ADDI  = 6'd8;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] SRCB_B       = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal_op;
    } ctl_t;

endpackage

// File: rtl/mc_main_control_if.sv
// Control bus between the main control FSM (master) and the MIPS datapath (slave).
interface mc_main_control_if;

    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       IRWrite;
    logic       ALUSrcA;
    logic       RegWrite;
    logic       RegDst;
    logic [1:0] PCSource;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp, illegal_op, state
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp, illegal_op, state
    );

endinterface

// File: rtl/mc_next_state.sv
// Combinational next-state function of the main control FSM.
// MC_CONTROL_ADDI_EN adds the ADDIEXEC/ADDICOMP path; otherwise ADDI decodes as illegal.
module mc_next_state
    import mc_pkg::*;
#(
    parameter logic [5:0] OP_RTYPE = OPC_RTYPE,
    parameter logic [5:0] OP_LW    = OPC_LW,
    parameter logic [5:0] OP_SW    = OPC_SW,
    parameter logic [5:0] OP_BEQ   = OPC_BEQ,
    parameter logic [5:0] OP_J     = OPC_J,
    parameter logic [5:0] OP_ADDI  = OPC_ADDI
)
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output state_t     next_state,
    output logic       illegal
);

    always_comb begin
        next_state = S_FETCH;
        illegal    = 1'b0;
        case (state)
            S_FETCH:    next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW)
                    next_state = S_MEMADDR;
                else if (opcode == OP_RTYPE)
                    next_state = S_EXECUTE;
                else if (opcode == OP_BEQ)
                    next_state = S_BRANCH;
                else if (opcode == OP_J)
                    next_state = S_JUMP;
`ifdef MC_CONTROL_ADDI_EN
                else if (opcode == OP_ADDI)
                    next_state = S_ADDIEXEC;
`else
                else if (opcode == OP_ADDI)
                    illegal = 1'b1;
`endif
                else
                    illegal = 1'b1;
            end
            S_MEMADDR: begin
                // opcode is still stable here, so LW/SW is re-decoded rather than latched
                if (opcode == OP_LW)
                    next_state = S_MEMREAD;
                else if (opcode == OP_SW)
                    next_state = S_MEMWRITE;
                else
                    next_state = S_FETCH;
            end
            S_MEMREAD:  next_state = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: next_state = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTE:  next_state = S_RCOMPLETE;
`ifdef MC_CONTROL_ADDI_EN
            S_ADDIEXEC: next_state = S_ADDICOMP;
`endif
            default:    next_state = S_FETCH;
        endcase
    end

endmodule

// File: rtl/mc_main_control.sv
// Multicycle MIPS main control: state register plus per-state datapath control decode.
// Optional ADDI support is enabled by defining MC_CONTROL_ADDI_EN.
module mc_main_control
    import mc_pkg::*;
#(
    parameter logic [5:0] OP_RTYPE = OPC_RTYPE,
    parameter logic [5:0] OP_LW    = OPC_LW,
    parameter logic [5:0] OP_SW    = OPC_SW,
    parameter logic [5:0] OP_BEQ   = OPC_BEQ,
    parameter logic [5:0] OP_J     = OPC_J,
    parameter logic [5:0] OP_ADDI  = OPC_ADDI
)
(
    input  logic                clk,
    input  logic                reset_n,
    mc_main_control_if.master   bus
);

    state_t state_q;
    state_t state_d;
    logic   illegal_dec;
    ctl_t   ctl;

    mc_next_state #(
        .OP_RTYPE (OP_RTYPE),
        .OP_LW    (OP_LW),
        .OP_SW    (OP_SW),
        .OP_BEQ   (OP_BEQ),
        .OP_J     (OP_J),
        .OP_ADDI  (OP_ADDI)
    ) u_next_state (
        .state      (state_q),
        .opcode     (bus.opcode),
        .mem_ready  (bus.mem_ready),
        .next_state (state_d),
        .illegal    (illegal_dec)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= S_FETCH;
        else
            state_q <= state_d;
    end

    // Outputs are forced low while reset is held, even though the state reads FETCH.
    always_comb begin
        ctl = '0;
        if (reset_n) begin
            case (state_q)
                S_FETCH: begin
                    ctl.mem_read  = 1'b1;
                    ctl.alu_src_b = SRCB_FOUR;
                    ctl.alu_op    = ALU_ADD;
                    ctl.pc_source = PCSRC_ALU;
                    ctl.ir_write  = bus.mem_ready;
                    ctl.pc_write  = bus.mem_ready;
                end
                S_DECODE: begin
                    ctl.alu_src_b  = SRCB_IMM_SH2;
                    ctl.alu_op     = ALU_ADD;
                    ctl.illegal_op = illegal_dec;
                end
                S_MEMADDR: begin
                    ctl.alu_src_a = 1'b1;
                    ctl.alu_src_b = SRCB_IMM;
                    ctl.alu_op    = ALU_ADD;
                end
                S_MEMREAD: begin
                    ctl.mem_read = 1'b1;
                    ctl.iord     = 1'b1;
                end
                S_MEMWB: begin
                    ctl.reg_write  = 1'b1;
                    ctl.mem_to_reg = 1'b1;
                end
                S_MEMWRITE: begin
                    ctl.mem_write = 1'b1;
                    ctl.iord      = 1'b1;
                end
                S_EXECUTE: begin
                    ctl.alu_src_a = 1'b1;
                    ctl.alu_src_b = SRCB_B;
                    ctl.alu_op    = ALU_FUNCT;
                end
                S_RCOMPLETE: begin
                    ctl.reg_write = 1'b1;
                    ctl.reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    ctl.alu_src_a     = 1'b1;
                    ctl.alu_src_b     = SRCB_B;
                    ctl.alu_op        = ALU_SUB;
                    ctl.pc_write_cond = 1'b1;
                    ctl.pc_source     = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    ctl.pc_write  = 1'b1;
                    ctl.pc_source = PCSRC_JUMP;
                end
`ifdef MC_CONTROL_ADDI_EN
                S_ADDIEXEC: begin
                    ctl.alu_src_a = 1'b1;
                    ctl.alu_src_b = SRCB_IMM;
                    ctl.alu_op    = ALU_ADD;
                end
                S_ADDICOMP: begin
                    ctl.reg_write = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.PCWrite     = ctl.pc_write;
    assign bus.PCWriteCond = ctl.pc_write_cond;
    assign bus.IorD        = ctl.iord;
    assign bus.MemRead     = ctl.mem_read;
    assign bus.MemWrite    = ctl.mem_write;
    assign bus.MemtoReg    = ctl.mem_to_reg;
    assign bus.IRWrite     = ctl.ir_write;
    assign bus.ALUSrcA     = ctl.alu_src_a;
    assign bus.RegWrite    = ctl.reg_write;
    assign bus.RegDst      = ctl.reg_dst;
    assign bus.PCSource    = ctl.pc_source;
    assign bus.ALUSrcB     = ctl.alu_src_b;
    assign bus.ALUOp       = ctl.alu_op;
    assign bus.illegal_op  = ctl.illegal_op;
    assign bus.state       = state_q;

endmodule
